// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit carry slice per stage,
// global-stall valid/ready handshake, carry/overflow/zero flags on the last stage.

module pipelined_addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  // Stage s holds the finished low sum bits and forwards only the operand
  // bits that later stages still have to add, so every register bit is live.
  for (genvar s = 0; s < STAGES; s++) begin : st
    localparam int L = s * CHUNK;
    localparam int H = WIDTH - L;

    logic [H-1:0]       ar_i, br_i;
    logic               c_i, v_i;
    logic [CHUNK-1:0]   ps;
    logic               pc;
    logic [L+CHUNK-1:0] s_n, s_r;
    logic               c_r, v_r;

    if (s == 0) begin : g_src
      assign ar_i = a;
      assign br_i = b_eff;
      assign c_i  = c0;
      assign v_i  = in_valid;
      assign s_n  = ps;
    end else begin : g_src
      assign ar_i = st[s-1].g_fwd.ar_r;
      assign br_i = st[s-1].g_fwd.br_r;
      assign c_i  = st[s-1].c_r;
      assign v_i  = st[s-1].v_r;
      assign s_n  = {ps, st[s-1].s_r};
    end

    pipelined_addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (ar_i[CHUNK-1:0]),
      .b  (br_i[CHUNK-1:0]),
      .ci (c_i),
      .s  (ps),
      .co (pc)
    );

    // Bubbles advance the valid bit only; data registers keep the last beat.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= v_i;
        if (v_i) begin
          c_r <= pc;
          s_r <= s_n;
        end
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [H-CHUNK-1:0] ar_r, br_r;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ar_r <= '0;
          br_r <= '0;
        end else if (adv && v_i) begin
          ar_r <= ar_i[H-1:CHUNK];
          br_r <= br_i[H-1:CHUNK];
        end
      end
    end else begin : g_flag
      logic ovf_r, zero_r;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (adv && v_i) begin
          ovf_r  <= (ar_i[H-1] == br_i[H-1]) && (ps[CHUNK-1] != ar_i[H-1]);
          zero_r <= (s_n == '0);
        end
      end
    end
  end

  assign out_valid = st[STAGES-1].v_r;
  assign sum       = st[STAGES-1].s_r;
  assign cout      = st[STAGES-1].c_r;
  assign ovf       = st[STAGES-1].g_flag.ovf_r;
  assign zero      = st[STAGES-1].g_flag.zero_r;
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor for the lab datapath. It generalises the 4-bit ripple-carry adder to WIDTH bits, adds a subtract mode, carry-in, signed-overflow and zero flags, and a valid/ready handshake. The carry chain is split into CHUNK-bit slices, with one slice per pipeline stage, so the clock rate does not depend on WIDTH. It sits between operand registers and the result or flag consumers, such as the ALU writeback and the seven-segment display driver.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per pipeline stage. STAGES = WIDTH/CHUNK, and STAGES must be at least 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when add; borrow-in when subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

## Operation
- Effective operands:
  - b_eff = sub ? ~b : b
  - c0 = sub ? ~cin : cin
  - Result = a + b_eff + c0, taken modulo 2^WIDTH.
  - Add: a+b+cin. Subtract: a−b−cin.
- cout is the raw carry out of bit WIDTH−1. In subtract mode cout=1 means no borrow; it is not inverted.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- zero = (sum == 0), computed on the final stage.
- Stage k (0..STAGES−1):
  - Adds slice k of a and b_eff plus the carry registered by stage k−1 (c0 for stage 0).
  - Registers the CHUNK-bit partial sum and the carry out.
- Unprocessed upper slices and already-computed lower sum slices travel with the beat in skew registers. Each stage carries a valid bit.
- Flow control is a global stall:
  - adv = !out_valid || out_ready
  - in_ready = adv (combinational)
  - When adv=1, every stage shifts one position.
  - When adv=0, all stage registers, including valids, hold.
- A beat is accepted when in_valid && in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Output registers hold sum, cout, ovf and zero stable while out_valid && !out_ready.
- Results emerge strictly in acceptance order. No beat is dropped or duplicated.
- Degenerate case STAGES=1: a single registered full-width add, with the same handshake.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - All stage valids clear; out_valid=0; sum=0; cout=0; ovf=0; zero=0.
  - Data registers may be cleared.
  - in_ready=1 from the first cycle after reset, because out_valid=0.
- Reset mid-operation discards every in-flight beat. None of them reappears after rst_n returns high.
- Latency: a beat accepted at edge t is presented with out_valid=1 after edge t+STAGES−1, i.e. visible in cycle t+STAGES, provided there was no stall in between.
- Each stalled cycle adds exactly one cycle of latency.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: the output retires and a new beat enters on the same edge.
- Wrap-around: results always truncate to WIDTH bits; the only indication of wrap-around is cout/ovf.

## Test plan
WIDTH=16, CHUNK=4, latency 4.
- add 0x00FF+0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0, zero=0, out_valid exactly 4 cycles after acceptance.
- add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1; add 0x7FFF+0x0000, cin=1 -> sum=0x8000, ovf=1, cout=0.
- sub 0x0005−0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000−0x0001 -> sum=0x7FFF, cout=1, ovf=1; sub 0x0010−0x000F, cin=1 -> sum=0x0000, zero=1.
- 8 back-to-back beats (a=i, b=0x1000·i) with out_ready low in cycles 5-7:
  - in_ready low in exactly those cycles;
  - held outputs stable;
  - all 8 results in order, with no gaps or duplicates after release.
- rst_n low for one cycle while 3 beats are in flight -> out_valid=0 and sum=0 next cycle; no stale result ever appears; a new beat afterwards completes normally in 4 cycles.
- Random regression (≥10k beats, random in_valid/out_ready/sub/cin) checked against a reference model; repeat with CHUNK=16 (STAGES=1) and WIDTH=32/CHUNK=8.
